// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer: plays a preloaded list of 16-bit Knight commands into RemoteComm,
// one at a time, each gated on a positive ack. Build macro TOUR_RETRY_EN adds per-command retries.
module tour_cmd_sequencer #(
    parameter int          DEPTH    = 32,
    parameter logic [7:0]  POS_ACK  = 8'hA5,
    parameter logic [23:0] TMO_CLKS = 24'd5000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    input  logic [$clog2(DEPTH):0]   num_cmds,
    input  logic                     start,
    input  logic                     abort,
    output logic [15:0]              cmd,
    output logic                     snd_cmd,
    input  logic                     cmd_snt,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     done,
    output logic                     err,
    output logic [2:0]               dbg_state
);

    // Handshake: snd_cmd is a 1-clk request with cmd already valid; cmd stays stable until
    // cmd_snt (1 clk) is seen in WAIT_SNT; resp is only taken on a resp_rdy clk in WAIT_RESP.

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
        WAIT_SNT  = 3'd3,
        WAIT_RESP = 3'd4,
        FIN       = 3'd5,
        FAIL      = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   cmd_q, cmd_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   count_q, count_d;
    logic [23:0]   tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          zdone_q, zdone_d;
    logic          snd;
    logic          wr_ok;
    logic          last_cmd;
`ifdef TOUR_RETRY_EN
    logic [1:0]    retry_q, retry_d;
`endif

    assign last_cmd = ({1'b0, idx_q} == (count_q - {{AW{1'b0}}, 1'b1}));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        zdone_d = 1'b0;
        snd     = 1'b0;
        wr_ok   = 1'b0;
`ifdef TOUR_RETRY_EN
        retry_d = retry_q;
`endif
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    wr_ok = wr_en;
                    if (start) begin
                        err_d = 1'b0;
`ifdef TOUR_RETRY_EN
                        retry_d = 2'd0;
`endif
                        if (num_cmds != '0) begin
                            idx_d   = '0;
                            count_d = num_cmds;
                            state_d = LOAD;
                        end else begin
                            zdone_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    cmd_d   = mem_q[idx_q];
                    state_d = SEND;
                end
                SEND: begin
                    snd     = 1'b1;
                    state_d = WAIT_SNT;
                end
                WAIT_SNT: begin
                    if (cmd_snt) begin
                        tmo_d   = '0;
                        state_d = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    tmo_d = tmo_q + 24'd1;
                    // A response on the last timeout clk still counts as a response.
                    if (resp_rdy) begin
                        if (resp == POS_ACK) begin
`ifdef TOUR_RETRY_EN
                            retry_d = 2'd0;
`endif
                            if (last_cmd) begin
                                state_d = FIN;
                            end else begin
                                idx_d   = idx_q + {{(AW-1){1'b0}}, 1'b1};
                                state_d = LOAD;
                            end
                        end else begin
                            state_d = FAIL;
                        end
                    end else if (tmo_q == (TMO_CLKS - 24'd1)) begin
                        state_d = FAIL;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                FAIL: begin
`ifdef TOUR_RETRY_EN
                    if (retry_q != 2'd2) begin
                        retry_d = retry_q + 2'd1;
                        state_d = LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
`else
                    err_d   = 1'b1;
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            zdone_q <= 1'b0;
`ifdef TOUR_RETRY_EN
            retry_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            zdone_q <= zdone_d;
`ifdef TOUR_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    // The command list is plain RAM and survives reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign cmd       = cmd_q;
    assign snd_cmd   = snd;
    assign busy      = (state_q != IDLE);
    assign idx       = idx_q;
    assign done      = ((state_q == FIN) | zdone_q) & ~abort;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: table of whole tours against a RemoteComm responder model,
// plus hand-written sequences for latency, timeout, abort, busy-ignore and reset corners.
module tb_tour_cmd_sequencer;

    localparam int          DEPTH = 32;
    localparam logic [23:0] TMO   = 24'd20;
    localparam int          TMOI  = 20;
`ifdef TOUR_RETRY_EN
    localparam int RETRY_EXTRA = 2;
`else
    localparam int RETRY_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [5:0]  num_cmds;
    logic        start;
    logic        abort;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic [4:0]  idx;
    logic        done;
    logic        err;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         n;
        int         nack_at;
        int         silent_at;
        int         exp_snd;
        int         exp_done;
        logic       exp_err;
        logic [4:0] exp_idx;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] exp_words [DEPTH];

    tour_cmd_sequencer #(
        .DEPTH(DEPTH), .POS_ACK(8'hA5), .TMO_CLKS(TMO)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_cmds(num_cmds), .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .idx(idx),
        .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns at the negedge after start was sampled (DUT in LOAD).
    task automatic start_tour(input int n);
        @(negedge clk);
        start = 1'b1; num_cmds = 6'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic abort_now();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic run_tour(input int v);
        int  m, snd_cnt, done_cnt, phase, wait_c, cyc;
        bit  fin;
        m = 0; snd_cnt = 0; done_cnt = 0; phase = 0; wait_c = 0; cyc = 0; fin = 0;
        start_tour(vecs[v].n);
        while (!fin && cyc < 3000) begin
            if (done) done_cnt++;
            if (!busy) begin
                fin = 1;
            end else begin
                case (phase)
                    0: if (snd_cmd) begin
                        snd_cnt++;
                        check($sformatf("v%0d cmd", v), cmd, exp_words[m]);
                        check($sformatf("v%0d idx", v), idx, m);
                        phase = 1; wait_c = 1;
                    end
                    1: if (wait_c == 0) begin
                        cmd_snt = 1'b1; phase = 2; wait_c = 2;
                    end else wait_c--;
                    2: begin
                        cmd_snt = 1'b0;
                        if (wait_c == 0) begin
                            if (m == vecs[v].silent_at) phase = 0;
                            else begin
                                resp_rdy = 1'b1;
                                resp = (m == vecs[v].nack_at) ? 8'h5A : 8'hA5;
                                phase = 3;
                            end
                        end else wait_c--;
                    end
                    default: begin
                        resp_rdy = 1'b0;
                        if (resp == 8'hA5) m++;
                        phase = 0;
                    end
                endcase
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        cmd_snt = 1'b0; resp_rdy = 1'b0;
        check($sformatf("v%0d finished in budget", v), fin, 1'b1);
        check($sformatf("v%0d snd count", v), snd_cnt, vecs[v].exp_snd);
        check($sformatf("v%0d done count", v), done_cnt, vecs[v].exp_done);
        check($sformatf("v%0d err", v), err, vecs[v].exp_err);
        check($sformatf("v%0d idx end", v), idx, vecs[v].exp_idx);
    endtask

    initial begin
        vecs[0] = '{n: 3,  nack_at: -1, silent_at: -1, exp_snd: 3,               exp_done: 1, exp_err: 1'b0, exp_idx: 5'd2};
        vecs[1] = '{n: 3,  nack_at: 1,  silent_at: -1, exp_snd: 2 + RETRY_EXTRA, exp_done: 0, exp_err: 1'b1, exp_idx: 5'd1};
        vecs[2] = '{n: 3,  nack_at: -1, silent_at: 0,  exp_snd: 1 + RETRY_EXTRA, exp_done: 0, exp_err: 1'b1, exp_idx: 5'd0};
        vecs[3] = '{n: 1,  nack_at: -1, silent_at: -1, exp_snd: 1,               exp_done: 1, exp_err: 1'b0, exp_idx: 5'd0};
        vecs[4] = '{n: 32, nack_at: -1, silent_at: -1, exp_snd: 32,              exp_done: 1, exp_err: 1'b0, exp_idx: 5'd31};
        vecs[5] = '{n: 2,  nack_at: 0,  silent_at: -1, exp_snd: 1 + RETRY_EXTRA, exp_done: 0, exp_err: 1'b1, exp_idx: 5'd0};
        exp_words[0] = 16'h2000;
        exp_words[1] = 16'h4BF1;
        exp_words[2] = 16'h57F2;
        for (int i = 3; i < DEPTH; i++) exp_words[i] = 16'(16'hC000 + i * 16'h0111);

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_cmds = '0;
        start = 1'b0; abort = 1'b0; cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
        repeat (3) @(negedge clk);
        check("rst cmd", cmd, 16'h0);
        check("rst snd_cmd", snd_cmd, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst idx", idx, 5'd0);
        check("rst done", done, 1'b0);
        check("rst err", err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) write_word(5'(i), exp_words[i]);

        // num_cmds == 0: done on the next clk, never busy, never sends.
        start_tour(0);
        check("zero done", done, 1'b1);
        check("zero busy", busy, 1'b0);
        check("zero snd", snd_cmd, 1'b0);
        @(negedge clk);
        check("zero done once", done, 1'b0);

        // Start-to-snd latency, then abort in WAIT_SNT.
        start_tour(3);
        check("lat load state", dbg_state, 3'd1);
        check("lat snd early", snd_cmd, 1'b0);
        @(negedge clk);
        check("lat snd", snd_cmd, 1'b1);
        check("lat cmd", cmd, 16'h2000);
        @(negedge clk);
        check("snd one clk", snd_cmd, 1'b0);
        check("wait_snt state", dbg_state, 3'd3);
        abort = 1'b1;
        #1 check("abort done", done, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort done after", done, 1'b0);

        // Abort during SEND masks snd_cmd that clk.
        start_tour(1);
        @(negedge clk);
        abort = 1'b1;
        #1 check("abort snd masked", snd_cmd, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        check("abort send busy", busy, 1'b0);

        // Write and start in the same clk: playback reads the new word.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'h3A5C; start = 1'b1; num_cmds = 6'd1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        @(negedge clk);
        check("wr+start snd", snd_cmd, 1'b1);
        check("wr+start cmd", cmd, 16'h3A5C);
        abort_now();
        write_word(5'd0, 16'h2000);

        // start and wr_en while busy are ignored; stray cmd_snt/resp_rdy in SEND ignored.
        start_tour(1);
        @(negedge clk);
        start = 1'b1; num_cmds = 6'd5; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hFFFF;
        cmd_snt = 1'b1; resp_rdy = 1'b1; resp = 8'h5A;
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0; cmd_snt = 1'b0; resp_rdy = 1'b0;
        check("stray cmd_snt ignored", dbg_state, 3'd3);
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0; resp_rdy = 1'b1; resp = 8'hA5;
        @(negedge clk);
        resp_rdy = 1'b0;
        check("busy-ign done", done, 1'b1);
        check("busy-ign busy in FIN", busy, 1'b1);
        @(negedge clk);
        check("busy-ign busy", busy, 1'b0);
        check("busy-ign err", err, 1'b0);

        // Timeout: FAIL exactly TMO clks after cmd_snt is taken.
        start_tour(1);
        repeat (2) @(negedge clk);
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
        repeat (TMOI - 1) @(negedge clk);
        check("tmo not yet", dbg_state, 3'd4);
        @(negedge clk);
        check("tmo fail state", dbg_state, 3'd6);
        @(negedge clk);
`ifdef TOUR_RETRY_EN
        check("tmo retry busy", busy, 1'b1);
        check("tmo retry err", err, 1'b0);
        abort_now();
`else
        check("tmo busy", busy, 1'b0);
        check("tmo err", err, 1'b1);
`endif

        // Ack on the final timeout clk beats the timeout.
        start_tour(1);
        repeat (2) @(negedge clk);
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
        repeat (TMOI - 1) @(negedge clk);
        resp_rdy = 1'b1; resp = 8'hA5;
        @(negedge clk);
        resp_rdy = 1'b0;
        check("late ack done", done, 1'b1);
        @(negedge clk);
        check("late ack busy", busy, 1'b0);
        check("late ack err", err, 1'b0);

        for (int v = 0; v < 6; v++) run_tour(v);

        // Reset mid WAIT_RESP acts immediately; list survives.
        start_tour(3);
        repeat (2) @(negedge clk);
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
        check("pre-rst state", dbg_state, 3'd4);
        #2 rst = 1'b1;
        #1;
        check("async rst cmd", cmd, 16'h0);
        check("async rst busy", busy, 1'b0);
        check("async rst idx", idx, 5'd0);
        check("async rst done", done, 1'b0);
        check("async rst err", err, 1'b0);
        check("async rst snd", snd_cmd, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_tour(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
